hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk_i  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port instr_i  input  32  instruction currently in ID.
REQ-004 SHALL have port id_valid_i  input  1  instr_i is a real instruction (0 = bubble).
REQ-005 SHALL have port mispred_i  input  1  EX-stage branch resolved against always-taken prediction.
REQ-006 SHALL have port hazard_op_o  output  6  forwarding code consumed by the forward stage.
REQ-007 SHALL have port branch_o  output  1  ID instruction is B-type (opcode 1100011).
REQ-008 SHALL have port stall_o  output  1  hold PC and IF/ID, insert bubble into EX.
REQ-009 SHALL have port flush_o  output  1  squash IF/ID and ID/EX contents.

Function
REQ-010 SHALL keep a 3-entry destination tracker (EX, MEM, WB); each entry holds {valid, rd[4:0], is_load}.
REQ-011 SHALL decode from instr_i: rd-write for opcodes other than S, B and FENCE; is_load for opcode 0000011; rs1 used except LUI/AUIPC/JAL; rs2 used for R, S and B only.
REQ-012 SHALL never flag a hazard on x0 and SHALL ignore entries with valid=0.
REQ-013 SHALL encode hazard_op_o as: bit5 = rs2 hazard, bit4 = rs1 hazard, [3:2] = rs2 source, [1:0] = rs1 source.
REQ-014 SHALL use source field encodings 00 = EX, 01 = MEM, 11 = WB and 10 = no hazard on that operand.
REQ-015 SHALL resolve multiple matches by priority EX > MEM > WB.
REQ-016 SHALL output hazard_op_o = 0 when neither operand has a hazard.
REQ-017 SHALL implement FSM states RUN, LDSTALL and FLUSH.
REQ-018 In RUN, when the EX entry is a load and its rd matches a used rs of a valid ID instruction, SHALL enter LDSTALL.
REQ-019 In RUN, when mispred_i=1, SHALL enter FLUSH; mispred_i SHALL take priority over load-use.
REQ-020 In LDSTALL (exactly 1 cycle): stall_o=1; hazard_op_o=6'b001111; tracker shifts with a bubble into EX; SHALL return to RUN.
REQ-021 In FLUSH (exactly 1 cycle): flush_o=1; hazard_op_o=6'b000111; bubble into EX; SHALL return to RUN.
REQ-022 In RUN, each cycle SHALL shift the tracker WB<-MEM<-EX and load EX from the decoded ID instruction; id_valid_i=0 loads a bubble.
REQ-023 Outputs SHALL be combinational from the current state, tracker and instr_i; branch_o SHALL be valid in all states.
REQ-024 A mispred_i pulse during LDSTALL SHALL be honoured by entering FLUSH on the next cycle instead of RUN.

Reset
REQ-025 While rst_i=1 at a clock edge, SHALL clear all tracker valid bits and set state to RUN.
REQ-026 After reset, SHALL drive hazard_op_o=0, stall_o=0 and flush_o=0.
REQ-027 Reset SHALL override an in-progress LDSTALL or FLUSH.

Configuration
REQ-028 When HAZARD_WB_FWD_EN is defined, SHALL report WB-entry matches with source code 11.
REQ-029 When HAZARD_WB_FWD_EN is undefined, SHALL ignore WB-entry matches, since the register file writes through; the operand field SHALL be 10 unless an EX or MEM match exists.

Verification
REQ-030 Bench SHALL check: add x5,x1,x2 then add x6,x5,x3 back-to-back -> second in ID: hazard_op_o=6'b011000, stall_o=0.
REQ-031 Bench SHALL check: lw x7,0(x1) then add x8,x2,x7 -> stall_o=1 for 1 cycle with hazard_op_o=6'b001111; next cycle hazard_op_o=6'b100110.
REQ-032 Bench SHALL check: add x5 in EX, sub x5 in MEM, ID uses rs1=x5 -> hazard_op_o=6'b011000 (EX wins).
REQ-033 Bench SHALL check: mispred_i=1 coincident with a load-use match -> flush_o=1, stall_o=0, hazard_op_o=6'b000111; next instruction sees no EX hazard.
REQ-034 Bench SHALL check: producer 3 instructions ahead, rs1 match in WB -> with HAZARD_WB_FWD_EN: hazard_op_o=6'b011011; without it: 0.
REQ-035 Bench SHALL check: rst_i asserted during LDSTALL -> next cycle stall_o=0 and hazard_op_o=0; an add using x0 as rd never produces a hazard.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit -- ID-stage hazard detection for a 5-stage in-order pipeline.
//
// Tracks the destination registers of the instructions in EX, MEM and WB.
// It tells the forward stage where each ID source operand must come from,
// and it sequences the one-cycle load-use stall and the one-cycle
// mispredict flush.
//
// Ports
//   clk_i        pipeline clock, rising edge
//   rst_i        synchronous, active-high reset
//   instr_i      instruction currently in ID
//   id_valid_i   instr_i is real (0 = bubble)
//   mispred_i    EX branch resolved against the always-taken prediction
//   hazard_op_o  {rs2_hit, rs1_hit, rs2_src[1:0], rs1_src[1:0]}
//                src: 00 = EX, 01 = MEM, 11 = WB, 10 = none
//   branch_o     ID instruction is B-type
//   stall_o      hold PC and IF/ID, bubble into EX
//   flush_o      squash IF/ID and ID/EX
//
// Build option
//   HAZARD_WB_FWD_EN  report WB-entry matches (source 11). When it is left
//                     undefined, the register file writes through, so WB
//                     matches are ignored.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow, tracker shifts and captures the ID instruction
// LDSTALL  | one-cycle load-use stall, bubble shifted into EX
// FLUSH    | one-cycle squash after a mispredict, bubble shifted into EX

module hazard_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        id_valid_i,
   input  logic        mispred_i,
   output logic [5:0]  hazard_op_o,
   output logic        branch_o,
   output logic        stall_o,
   output logic        flush_o
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LDSTALL = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_FENCE = 7'b0001111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [5:0] OP_STALL = 6'b001111;
   localparam logic [5:0] OP_FLUSH = 6'b000111;

   // Tracker entry: {valid, rd[4:0], is_load}; index 0 = EX, 1 = MEM, 2 = WB.
   logic [6:0] trk [3];
   logic [1:0] state;
   logic [1:0] state_nxt;

   logic [6:0] opcode;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       use_rs1;
   logic       use_rs2;
   logic       writes_rd;
   logic [6:0] id_entry;

   assign opcode    = instr_i[6:0];
   assign rd        = instr_i[11:7];
   assign rs1       = instr_i[19:15];
   assign rs2       = instr_i[24:20];
   assign use_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign use_rs2   = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BR);
   assign writes_rd = !(opcode == OP_STORE || opcode == OP_BR || opcode == OP_FENCE);
   assign id_entry  = {id_valid_i & writes_rd, rd, opcode == OP_LOAD};
   assign branch_o  = (opcode == OP_BR);

   // x0 is never a hazard: an rs of zero can never match.
   function automatic logic match(input logic [6:0] ent, input logic [4:0] rs,
                                  input logic used);
      return used && (rs != 5'd0) && ent[6] && (ent[5:1] == rs);
   endfunction

   logic rs1_ex, rs1_mem, rs1_wb;
   logic rs2_ex, rs2_mem, rs2_wb;

   assign rs1_ex  = match(trk[0], rs1, use_rs1);
   assign rs2_ex  = match(trk[0], rs2, use_rs2);
   assign rs1_mem = match(trk[1], rs1, use_rs1);
   assign rs2_mem = match(trk[1], rs2, use_rs2);
`ifdef HAZARD_WB_FWD_EN
   assign rs1_wb  = match(trk[2], rs1, use_rs1);
   assign rs2_wb  = match(trk[2], rs2, use_rs2);
`else
   assign rs1_wb  = 1'b0;
   assign rs2_wb  = 1'b0;
`endif

   // Fields that nothing downstream consumes; kept so the tracker stays uniform.
   logic unused_bits;
   assign unused_bits = ^{instr_i[31:25], instr_i[14:12], trk[1][0], trk[2]};

   logic       rs1_hit, rs2_hit;
   logic [1:0] rs1_src, rs2_src;
   logic [5:0] op_run;
   logic       load_use;

   assign rs1_hit = id_valid_i & (rs1_ex | rs1_mem | rs1_wb);
   assign rs2_hit = id_valid_i & (rs2_ex | rs2_mem | rs2_wb);

   // Youngest producer wins: EX > MEM > WB.
   always_comb begin
      rs1_src = 2'b10;
      if (rs1_ex)       rs1_src = 2'b00;
      else if (rs1_mem) rs1_src = 2'b01;
      else if (rs1_wb)  rs1_src = 2'b11;
      rs2_src = 2'b10;
      if (rs2_ex)       rs2_src = 2'b00;
      else if (rs2_mem) rs2_src = 2'b01;
      else if (rs2_wb)  rs2_src = 2'b11;
   end

   assign op_run   = (rs1_hit | rs2_hit) ? {rs2_hit, rs1_hit, rs2_src, rs1_src} : 6'd0;
   assign load_use = id_valid_i & trk[0][0] & (rs1_ex | rs2_ex);

   logic shift_en;
   logic ins_bubble;

   always_comb begin
      state_nxt   = ST_RUN;
      shift_en    = 1'b1;
      ins_bubble  = 1'b0;
      stall_o     = 1'b0;
      flush_o     = 1'b0;
      hazard_op_o = op_run;
      case (state)
         ST_RUN: begin
            if (mispred_i) begin
               // The ID instruction is wrong-path; do not track it.
               state_nxt  = ST_FLUSH;
               ins_bubble = 1'b1;
            end else if (load_use) begin
               // Hold the tracker so the load is still in EX during the stall
               // and reaches MEM exactly when the consumer resumes.
               state_nxt = ST_LDSTALL;
               shift_en  = 1'b0;
            end
         end
         ST_LDSTALL: begin
            stall_o     = 1'b1;
            hazard_op_o = OP_STALL;
            ins_bubble  = 1'b1;
            if (mispred_i) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush_o     = 1'b1;
            hazard_op_o = OP_FLUSH;
            ins_bubble  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= ST_RUN;
         trk[0] <= 7'd0;
         trk[1] <= 7'd0;
         trk[2] <= 7'd0;
      end else begin
         state <= state_nxt;
         if (shift_en) begin
            trk[2] <= trk[1];
            trk[1] <= trk[0];
            trk[0] <= ins_bubble ? 7'd0 : id_entry;
         end
      end
   end

endmodule
